// File: rtl/datapath_core.sv
// CPU datapath core: 16-entry, 2-write/2-read register file feeding a combinational ALU.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module datapath_core #(
  parameter int WIDTH_WORD   = 8,
  parameter int WIDTH_SEG    = 4,
  parameter int WIDTH_DOUBLE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [WIDTH_SEG-1:0]    wa0,
  input  logic [WIDTH_SEG-1:0]    wa1,
  input  logic [WIDTH_WORD-1:0]   wd0,
  input  logic [WIDTH_WORD-1:0]   wd1,
  input  logic [WIDTH_SEG-1:0]    ra0,
  input  logic [WIDTH_SEG-1:0]    ra1,
  output logic [WIDTH_WORD-1:0]   rd0,
  output logic [WIDTH_WORD-1:0]   rd1,
  output logic [WIDTH_DOUBLE-1:0] rd_pair,
  input  logic                    alu_en,
  input  logic [2:0]              alu_func,
  output logic [WIDTH_WORD-1:0]   alu_res,
  output logic                    alu_carry,
  output logic                    alu_zero
);

  localparam int unsigned NUM_REGS = 2 ** WIDTH_SEG;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_NOT = 3'd3,
    ALU_MV  = 3'd4,
    ALU_AND = 3'd5,
    ALU_XOR = 3'd6,
    ALU_B   = 3'd7
  } alu_op_e;

  logic [WIDTH_WORD-1:0] regs_q [NUM_REGS];
  logic [WIDTH_WORD-1:0] regs_d [NUM_REGS];

  // Port 1 is applied last so it wins a same-index collision.
  always_comb begin
    regs_d = regs_q;
    if (we0) regs_d[wa0] = wd0;
    if (we1) regs_d[wa1] = wd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so reads still show the cleared file.
  always_comb begin
    rd0 = regs_q[ra0];
    rd1 = regs_q[ra1];
    if (!rst) begin
      if (we1 && (wa1 == ra0))      rd0 = wd1;
      else if (we0 && (wa0 == ra0)) rd0 = wd0;
      if (we1 && (wa1 == ra1))      rd1 = wd1;
      else if (we0 && (wa0 == ra1)) rd1 = wd0;
    end
  end
`else
  always_comb begin
    rd0 = regs_q[ra0];
    rd1 = regs_q[ra1];
  end
`endif

  assign rd_pair = {rd1, rd0};

  logic [WIDTH_WORD:0] sum_ext;
  logic [WIDTH_WORD:0] diff_ext;

  always_comb begin
    sum_ext   = {1'b0, rd0} + {1'b0, rd1};
    diff_ext  = {1'b0, rd0} - {1'b0, rd1};
    alu_res   = '0;
    alu_carry = 1'b0;
    if (alu_en) begin
      unique case (alu_op_e'(alu_func))
        ALU_ADD: begin
          alu_res   = sum_ext[WIDTH_WORD-1:0];
          alu_carry = sum_ext[WIDTH_WORD];
        end
        ALU_SUB: begin
          alu_res   = diff_ext[WIDTH_WORD-1:0];
          alu_carry = diff_ext[WIDTH_WORD];
        end
        ALU_OR:  alu_res = rd0 | rd1;
        ALU_NOT: alu_res = ~rd0;
        ALU_MV:  alu_res = rd0;
        ALU_AND: alu_res = rd0 & rd1;
        ALU_XOR: alu_res = rd0 ^ rd1;
        ALU_B:   alu_res = rd1;
        default: alu_res = '0;
      endcase
    end
  end

  assign alu_zero = (alu_res == '0);

endmodule

// File: tb/tb_datapath_core.sv
// Directed self-checking bench for datapath_core; bypass expectations follow REGFILE_BYPASS_EN.
module tb_datapath_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  wa0 = '0, wa1 = '0, ra0 = '0, ra1 = '0;
  logic [7:0]  wd0 = '0, wd1 = '0;
  logic [7:0]  rd0, rd1, alu_res;
  logic [15:0] rd_pair;
  logic        alu_en = 1'b0;
  logic [2:0]  alu_func = '0;
  logic        alu_carry, alu_zero;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  datapath_core #(.WIDTH_WORD(8), .WIDTH_SEG(4), .WIDTH_DOUBLE(16)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1), .rd_pair(rd_pair),
    .alu_en(alu_en), .alu_func(alu_func),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic e0, input logic [3:0] a0, input logic [7:0] d0,
                    input logic e1, input logic [3:0] a1, input logic [7:0] d1);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
    tick();
    we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    ra0 = a; ra1 = b; alu_func = f; alu_en = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [2:0] func;
    logic [7:0] res;
    logic       carry;
  } alu_vec_t;

  alu_vec_t vecs[6];

  initial begin
    // A = 0x3C (R11), B = 0xA5 (R12)
    vecs[0] = '{3'd2, 8'hBD, 1'b0};
    vecs[1] = '{3'd3, 8'hC3, 1'b0};
    vecs[2] = '{3'd4, 8'h3C, 1'b0};
    vecs[3] = '{3'd5, 8'h24, 1'b0};
    vecs[4] = '{3'd6, 8'h99, 1'b0};
    vecs[5] = '{3'd7, 8'hA5, 1'b0};

    #1 rst = 1'b1;
    #3;
    check("rst_rd0", {8'h0, rd0}, 16'h0);
    check("rst_rd1", {8'h0, rd1}, 16'h0);
    check("rst_pair", rd_pair, 16'h0);
    check("rst_alu_res", {8'h0, alu_res}, 16'h0);
    check("rst_alu_zero", {15'h0, alu_zero}, 16'h1);
    tick();
    rst = 1'b0;
    #1;

    wr(1'b1, 4'd1, 8'd8, 1'b1, 4'd3, 8'd5);
    alu(4'd3, 4'd1, 3'd0);
    check("add_13_res", {8'h0, alu_res}, 16'd13);
    check("add_13_carry", {15'h0, alu_carry}, 16'h0);
    check("add_13_zero", {15'h0, alu_zero}, 16'h0);
    wr(1'b1, 4'd2, alu_res, 1'b0, 4'd0, 8'h0);
    ra0 = 4'd2; #1;
    check("r2_readback", {8'h0, rd0}, 16'd13);

    we0 = 1'b1; wa0 = 4'd14; wd0 = 8'h08;
    we1 = 1'b1; wa1 = 4'd15; wd1 = 8'h00;
    ra0 = 4'd14; ra1 = 4'd15;
    #1;
`ifndef REGFILE_BYPASS_EN
    check("pair_before_edge", rd_pair, 16'h0000);
`endif
    tick();
    we0 = 1'b0; we1 = 1'b0; #1;
    check("pair_0008", rd_pair, 16'h0008);
    wr(1'b1, 4'd14, 8'h0A, 1'b1, 4'd15, 8'h00);
    check("pair_000a", rd_pair, 16'h000A);
    wr(1'b1, 4'd15, 8'h12, 1'b1, 4'd14, 8'h34);
    check("pair_1234", rd_pair, 16'h1234);

    wr(1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 8'h22);
    ra0 = 4'd5; #1;
    check("collision_r5", {8'h0, rd0}, 16'h22);

    wr(1'b1, 4'd6, 8'hFF, 1'b1, 4'd7, 8'h01);
    alu(4'd6, 4'd7, 3'd0);
    check("add_wrap_res", {8'h0, alu_res}, 16'h00);
    check("add_wrap_carry", {15'h0, alu_carry}, 16'h1);
    check("add_wrap_zero", {15'h0, alu_zero}, 16'h1);

    wr(1'b1, 4'd8, 8'h03, 1'b1, 4'd9, 8'h05);
    alu(4'd8, 4'd9, 3'd1);
    check("sub_borrow_res", {8'h0, alu_res}, 16'hFE);
    check("sub_borrow_carry", {15'h0, alu_carry}, 16'h1);
    alu(4'd9, 4'd8, 3'd1);
    check("sub_ok_res", {8'h0, alu_res}, 16'h02);
    check("sub_ok_carry", {15'h0, alu_carry}, 16'h0);
    alu(4'd8, 4'd8, 3'd1);
    check("sub_eq_zero", {15'h0, alu_zero}, 16'h1);

    wr(1'b1, 4'd10, 8'h0F, 1'b0, 4'd0, 8'h0);
    alu(4'd10, 4'd9, 3'd3);
    check("not_0f", {8'h0, alu_res}, 16'hF0);
    check("not_carry", {15'h0, alu_carry}, 16'h0);

    wr(1'b1, 4'd11, 8'h3C, 1'b1, 4'd12, 8'hA5);
    foreach (vecs[i]) begin
      alu(4'd11, 4'd12, vecs[i].func);
      check($sformatf("func%0d_res", vecs[i].func), {8'h0, alu_res}, {8'h0, vecs[i].res});
      check($sformatf("func%0d_carry", vecs[i].func), {15'h0, alu_carry}, {15'h0, vecs[i].carry});
    end

    alu(4'd6, 4'd7, 3'd0);
    alu_en = 1'b0; #1;
    check("alu_dis_res", {8'h0, alu_res}, 16'h0);
    check("alu_dis_carry", {15'h0, alu_carry}, 16'h0);
    check("alu_dis_zero", {15'h0, alu_zero}, 16'h1);

    we0 = 1'b1; wa0 = 4'd4; wd0 = 8'h33; ra0 = 4'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd0", {8'h0, rd0}, 16'h33);
`else
    check("nobypass_rd0", {8'h0, rd0}, 16'h00);
`endif
    tick();
    we0 = 1'b0; #1;
    check("r4_after_edge", {8'h0, rd0}, 16'h33);

    // Reset arrives mid-cycle with a write pending; nothing may survive.
    we0 = 1'b1; wa0 = 4'd1; wd0 = 8'h77;
    we1 = 1'b1; wa1 = 4'd2; wd1 = 8'h66;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      ra0 = 4'(i); ra1 = 4'(15 - i);
      #1;
      check($sformatf("rst_r%0d_p0", i), {8'h0, rd0}, 16'h0);
      check($sformatf("rst_r%0d_p1", i), {8'h0, rd1}, 16'h0);
    end
    tick();
    tick();
    we0 = 1'b0; we1 = 1'b0;
    rst = 1'b0;
    ra0 = 4'd1; ra1 = 4'd2; #1;
    check("post_rst_r1", {8'h0, rd0}, 16'h0);
    check("post_rst_r2", {8'h0, rd1}, 16'h0);
    wr(1'b1, 4'd1, 8'h5A, 1'b0, 4'd0, 8'h0);
    check("post_rst_write", {8'h0, rd0}, 16'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
